// File: rtl/dmem_access_unit_if.sv
// rtl/dmem_access_unit_if.sv - CPU request/response and data-memory bus bundle for dmem_access_unit
interface dmem_access_unit_if;
    // CPU side
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    // Data-memory side
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_wena;
    logic [31:0] dm_rdata;

    modport slave (
        input  req, we, size, sext, addr, wdata, dm_rdata,
        output ready, done, rdata, addr_err, dm_addr, dm_wdata, dm_wena
    );

    modport master (
        output req, we, size, sext, addr, wdata, dm_rdata,
        input  ready, done, rdata, addr_err, dm_addr, dm_wdata, dm_wena
    );
endinterface

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - sub-word load/store sequencer (RMW stores, extended loads); DMEM_ALIGN_CHECK_EN enables misalignment detection
module dmem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state;
    state_t              state_nx;
    logic                we_q;
    logic                sext_q;
    logic                err_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         word_q;
    logic [31:0]         rdata_q;
    logic                misaligned;
    logic [ADDR_W-1:0]   addr_in;
    logic [31:0]         merged;
    logic [15:0]         lane;
    logic [31:0]         load_val;
    logic                unused_addr_hi;

    // Upper CPU address bits wrap away; they never reach the memory.
    assign unused_addr_hi = ^bus.addr[31:ADDR_W];

    // Classify the incoming request: flag misalignment or force natural alignment.
    always_comb begin
        misaligned = 1'b0;
        addr_in    = bus.addr[ADDR_W-1:0];
`ifdef DMEM_ALIGN_CHECK_EN
        if (bus.size == 2'b01) begin
            misaligned = bus.addr[0];
        end else if (bus.size[1]) begin
            misaligned = |bus.addr[1:0];
        end
`else
        if (bus.size == 2'b01) begin
            addr_in[0] = 1'b0;
        end else if (bus.size[1]) begin
            addr_in[1:0] = 2'b00;
        end
`endif
    end

    // Next-state decode; word stores skip the read, sub-word stores read first.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (misaligned) begin
                        state_nx = DONE;
                    end else if (bus.we && bus.size[1]) begin
                        state_nx = WRITE;
                    end else begin
                        state_nx = READ;
                    end
                end
            end
            READ:    state_nx = we_q ? WRITE : DONE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Store merge: replace the addressed lane(s) of the word read back.
    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load extract works on the word being captured so rdata lands on the same edge as word_q.
    always_comb begin
        lane     = 16'(bus.dm_rdata >> {addr_q[1:0], 3'b000});
        load_val = bus.dm_rdata;
        case (size_q)
            2'b00:   load_val = {{24{sext_q & lane[7]}}, lane[7:0]};
            2'b01:   load_val = {{16{sext_q & lane[15]}}, lane[15:0]};
            default: load_val = bus.dm_rdata;
        endcase
    end

    // State register plus request latch and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        size_q  <= bus.size;
                        sext_q  <= bus.sext;
                        addr_q  <= addr_in;
                        wdata_q <= bus.wdata;
                        err_q   <= misaligned;
                    end
                end
                READ: begin
                    word_q <= bus.dm_rdata;
                    if (!we_q) begin
                        rdata_q <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.done     = (state == DONE);
    assign bus.addr_err = (state == DONE) && err_q;
    assign bus.rdata    = rdata_q;
    assign bus.dm_addr  = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W-1:2], 2'b00};
    assign bus.dm_wena  = (state == WRITE);
    assign bus.dm_wdata = (state == WRITE) ? merged : 32'h0;

endmodule
